// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline control for the five-stage Beta core.
// Drives the per-stage IR source selects, stall/freeze, the PC source and
// the RF operand bypass selects. It also latches interrupt requests and masks
// further interrupts while an injected exception drains from EXEC to WB.
module pipe_ctrl #(
    parameter int EXC_DRAIN = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] rf_ra,
    input  logic [4:0] rf_rb,
    input  logic       rf_use_ra,
    input  logic       rf_use_rb,
    input  logic       rf_illegal,
    input  logic       rf_branch_taken,
    input  logic [4:0] exec_rc,
    input  logic [4:0] mem_rc,
    input  logic [4:0] wb_rc,
    input  logic       exec_wr,
    input  logic       mem_wr,
    input  logic       wb_wr,
    input  logic       exec_ld,
    input  logic       mem_ld,
    input  logic       mem_req,
    input  logic       mem_ready,
    input  logic       irq,
    output logic [1:0] ir_src_rf,
    output logic [1:0] ir_src_exec,
    output logic [1:0] ir_src_wb,
    output logic [1:0] pc_sel,
    output logic       stall,
    output logic       freeze,
    output logic [1:0] a_byp,
    output logic [1:0] b_byp,
    output logic       irq_pending,
    output logic       exc_busy
);

    // IR source encodings shared with the datapath muxes.
    localparam logic [1:0] IR_SRC_DATA   = 2'd0;
    localparam logic [1:0] IR_SRC_NOP    = 2'd1;
    localparam logic [1:0] IR_SRC_EXCEPT = 2'd2;

    localparam logic [1:0] PC_SEL_SEQ    = 2'd0;
    localparam logic [1:0] PC_SEL_BRANCH = 2'd1;
    localparam logic [1:0] PC_SEL_XADR   = 2'd2;

    localparam logic [1:0] BYP_RF   = 2'd0;
    localparam logic [1:0] BYP_EXEC = 2'd1;
    localparam logic [1:0] BYP_MEM  = 2'd2;
    localparam logic [1:0] BYP_WB   = 2'd3;

    localparam int CNT_W = (EXC_DRAIN > 1) ? $clog2(EXC_DRAIN) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(EXC_DRAIN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    typedef enum logic [0:0] {
        ST_RUN = 1'b0,
        ST_EXC = 1'b1
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             irq_pending_r;
    logic             irq_pending_nxt_s;

    logic ma_exec_s, ma_mem_s, ma_wb_s;
    logic mb_exec_s, mb_mem_s, mb_wb_s;
    logic hz_a_s, hz_b_s;
    logic load_use_s;
    logic mem_wait_s;
    logic irq_take_s;
    logic exc_take_s;
    logic [1:0] a_sel_s, b_sel_s;

    // A source matches a stage only when it is really read, really written,
    // and is not R31 (which always reads as zero).
    function automatic logic src_match(input logic [4:0] src, input logic use_src,
                                       input logic [4:0] rc, input logic wr);
        return use_src && wr && (rc == src) && (src != 5'd31);
    endfunction

    // Nearest producing stage wins.
    function automatic logic [1:0] byp_sel(input logic m_exec, input logic m_mem,
                                           input logic m_wb);
        logic [1:0] sel;
        if (m_exec) begin
            sel = BYP_EXEC;
        end else if (m_mem) begin
            sel = BYP_MEM;
        end else if (m_wb) begin
            sel = BYP_WB;
        end else begin
            sel = BYP_RF;
        end
        return sel;
    endfunction

    // Source matching, bypass selection and hazard/event detection.
    always_comb begin
        ma_exec_s = src_match(rf_ra, rf_use_ra, exec_rc, exec_wr);
        ma_mem_s  = src_match(rf_ra, rf_use_ra, mem_rc,  mem_wr);
        ma_wb_s   = src_match(rf_ra, rf_use_ra, wb_rc,   wb_wr);
        mb_exec_s = src_match(rf_rb, rf_use_rb, exec_rc, exec_wr);
        mb_mem_s  = src_match(rf_rb, rf_use_rb, mem_rc,  mem_wr);
        mb_wb_s   = src_match(rf_rb, rf_use_rb, wb_rc,   wb_wr);
        a_sel_s   = byp_sel(ma_exec_s, ma_mem_s, ma_wb_s);
        b_sel_s   = byp_sel(mb_exec_s, mb_mem_s, mb_wb_s);
        // A closer non-load producer shadows an older load to the same register.
        if (ma_exec_s) begin
            hz_a_s = exec_ld;
        end else begin
            hz_a_s = ma_mem_s && mem_ld;
        end
        if (mb_exec_s) begin
            hz_b_s = exec_ld;
        end else begin
            hz_b_s = mb_mem_s && mem_ld;
        end
        load_use_s = hz_a_s || hz_b_s;
        mem_wait_s = mem_req && !mem_ready;
        irq_take_s = irq_pending_r && (state_r == ST_RUN) && !mem_wait_s;
        exc_take_s = !mem_wait_s && (rf_illegal || irq_take_s);
    end

    // Prioritised pipeline control: freeze > exception > load-use > branch > normal.
    always_comb begin
        ir_src_rf   = IR_SRC_DATA;
        ir_src_exec = IR_SRC_DATA;
        ir_src_wb   = IR_SRC_DATA;
        pc_sel      = PC_SEL_SEQ;
        stall       = 1'b0;
        freeze      = 1'b0;
        a_byp       = a_sel_s;
        b_byp       = b_sel_s;
        if (!rst_n) begin
            ir_src_rf   = IR_SRC_NOP;
            ir_src_exec = IR_SRC_NOP;
            ir_src_wb   = IR_SRC_NOP;
            a_byp       = BYP_RF;
            b_byp       = BYP_RF;
        end else if (mem_wait_s) begin
            freeze    = 1'b1;
            ir_src_wb = IR_SRC_NOP;
        end else if (exc_take_s) begin
            // The replaced RF instruction re-executes after the handler.
            ir_src_exec = IR_SRC_EXCEPT;
            ir_src_rf   = IR_SRC_NOP;
            pc_sel      = PC_SEL_XADR;
        end else if (load_use_s) begin
            stall       = 1'b1;
            ir_src_exec = IR_SRC_NOP;
        end else if (rf_branch_taken) begin
            ir_src_rf = IR_SRC_NOP;
            pc_sel    = PC_SEL_BRANCH;
        end else begin
            pc_sel = PC_SEL_SEQ;
        end
    end

    // Next-state logic for the IRQ latch and the exception drain FSM.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        // A new request outranks the clear from a take in the same cycle.
        if (irq) begin
            irq_pending_nxt_s = 1'b1;
        end else if (irq_take_s) begin
            irq_pending_nxt_s = 1'b0;
        end else begin
            irq_pending_nxt_s = irq_pending_r;
        end
        case (state_r)
            ST_RUN: begin
                if (exc_take_s) begin
                    state_nxt_s = ST_EXC;
                    cnt_nxt_s   = CNT_LOAD;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_EXC: begin
                if (mem_wait_s) begin
                    cnt_nxt_s = cnt_r;
                end else if (rf_illegal) begin
                    cnt_nxt_s = CNT_LOAD;
                end else if (cnt_r == CNT_ZERO) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    cnt_nxt_s = cnt_r - CNT_ONE;
                end
            end
            default: begin
                state_nxt_s = ST_RUN;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase
    end

    // State, drain counter and IRQ latch registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r       <= ST_RUN;
            cnt_r         <= CNT_ZERO;
            irq_pending_r <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            cnt_r         <= cnt_nxt_s;
            irq_pending_r <= irq_pending_nxt_s;
        end
    end

    assign irq_pending = irq_pending_r;
    assign exc_busy    = (state_r == ST_EXC);

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl. Each test drives one cycle at a time,
// pushes the expected output vector onto a scoreboard and pops/compares it
// when the outputs are sampled on the falling edge.
module tb_pipe_ctrl;

    localparam logic [1:0] DAT = 2'd0;
    localparam logic [1:0] NOP = 2'd1;
    localparam logic [1:0] EXC = 2'd2;

    logic       clk;
    logic       rst_n;
    logic [4:0] rf_ra, rf_rb;
    logic       rf_use_ra, rf_use_rb, rf_illegal, rf_branch_taken;
    logic [4:0] exec_rc, mem_rc, wb_rc;
    logic       exec_wr, mem_wr, wb_wr, exec_ld, mem_ld;
    logic       mem_req, mem_ready, irq;
    logic [1:0] ir_src_rf, ir_src_exec, ir_src_wb, pc_sel, a_byp, b_byp;
    logic       stall, freeze, irq_pending, exc_busy;

    int n_chk;
    int n_fail;

    // {mask, expected} pairs and their names
    logic [31:0] sb_vec[$];
    string       sb_name[$];

    pipe_ctrl #(.EXC_DRAIN(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .rf_ra(rf_ra), .rf_rb(rf_rb), .rf_use_ra(rf_use_ra), .rf_use_rb(rf_use_rb),
        .rf_illegal(rf_illegal), .rf_branch_taken(rf_branch_taken),
        .exec_rc(exec_rc), .mem_rc(mem_rc), .wb_rc(wb_rc),
        .exec_wr(exec_wr), .mem_wr(mem_wr), .wb_wr(wb_wr),
        .exec_ld(exec_ld), .mem_ld(mem_ld),
        .mem_req(mem_req), .mem_ready(mem_ready), .irq(irq),
        .ir_src_rf(ir_src_rf), .ir_src_exec(ir_src_exec), .ir_src_wb(ir_src_wb),
        .pc_sel(pc_sel), .stall(stall), .freeze(freeze),
        .a_byp(a_byp), .b_byp(b_byp),
        .irq_pending(irq_pending), .exc_busy(exc_busy)
    );

    always #5 clk = ~clk;

    task automatic idle();
        rf_ra = 5'd0; rf_rb = 5'd0; rf_use_ra = 1'b0; rf_use_rb = 1'b0;
        rf_illegal = 1'b0; rf_branch_taken = 1'b0;
        exec_rc = 5'd0; mem_rc = 5'd0; wb_rc = 5'd0;
        exec_wr = 1'b0; mem_wr = 1'b0; wb_wr = 1'b0;
        exec_ld = 1'b0; mem_ld = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b0; irq = 1'b0;
    endtask

    // Expected-vector constructor; bc=0 marks the bypass selects don't-care.
    function automatic logic [31:0] mk(input logic [1:0] rf, input logic [1:0] ex,
                                       input logic [1:0] wb, input logic [1:0] pc,
                                       input logic st, input logic fr,
                                       input logic [1:0] ab, input logic [1:0] bb,
                                       input logic ip, input logic eb, input bit bc);
        logic [15:0] v;
        logic [15:0] m;
        v = {rf, ex, wb, pc, st, fr, ab, bb, ip, eb};
        m = bc ? 16'hFFFF : 16'hFFC3;
        return {m, v};
    endfunction

    function automatic logic [15:0] obs_vec();
        return {ir_src_rf, ir_src_exec, ir_src_wb, pc_sel, stall, freeze,
                a_byp, b_byp, irq_pending, exc_busy};
    endfunction

    task automatic push(input string n, input logic [31:0] e);
        sb_name.push_back(n);
        sb_vec.push_back(e);
    endtask

    task automatic test_reset();
        logic [31:0] ev; string en; logic [15:0] ov;
        for (int s = 0; s < 3; s++) begin
            @(posedge clk); #1;
            idle();
            case (s)
                0, 1: begin
                    rst_n = 1'b0; rf_branch_taken = 1'b1; rf_illegal = 1'b1;
                    rf_ra = 5'd3; rf_use_ra = 1'b1; exec_rc = 5'd3; exec_wr = 1'b1;
                    push("reset_hold", mk(NOP, NOP, NOP, 2'd0, 0, 0, 2'd0, 2'd0, 0, 0, 1));
                end
                default: begin
                    rst_n = 1'b1;
                    push("reset_release", mk(DAT, DAT, DAT, 2'd0, 0, 0, 2'd0, 2'd0, 0, 0, 1));
                end
            endcase
            @(negedge clk);
            n_chk++;
            if (sb_vec.size() == 0) begin
                n_fail++; $display("FAIL reset: scoreboard empty");
            end else begin
                ev = sb_vec.pop_front(); en = sb_name.pop_front(); ov = obs_vec();
                if (((ov ^ ev[15:0]) & ev[31:16]) !== 16'h0000) begin
                    n_fail++;
                    $display("FAIL %s step %0d: observed %b required %b mask %b", en, s, ov, ev[15:0], ev[31:16]);
                end
            end
        end
    endtask

    task automatic test_bypass();
        logic [31:0] ev; string en; logic [15:0] ov;
        for (int s = 0; s < 7; s++) begin
            @(posedge clk); #1;
            idle();
            rf_use_ra = 1'b1; rf_use_rb = 1'b1;
            case (s)
                0: begin
                    exec_rc = 5'd3; exec_wr = 1'b1; mem_rc = 5'd3; mem_wr = 1'b1;
                    wb_rc = 5'd3; wb_wr = 1'b1; rf_ra = 5'd3; rf_rb = 5'd31;
                    push("byp_chain", mk(DAT, DAT, DAT, 2'd0, 0, 0, 2'd1, 2'd0, 0, 0, 1));
                end
                1: begin
                    exec_rc = 5'd3; mem_rc = 5'd3; mem_wr = 1'b1;
                    wb_rc = 5'd3; wb_wr = 1'b1; rf_ra = 5'd3; rf_rb = 5'd31;
                    push("byp_mem", mk(DAT, DAT, DAT, 2'd0, 0, 0, 2'd2, 2'd0, 0, 0, 1));
                end
                2: begin
                    exec_rc = 5'd3; mem_rc = 5'd3; wb_rc = 5'd3; wb_wr = 1'b1;
                    rf_ra = 5'd3; rf_rb = 5'd31;
                    push("byp_wb", mk(DAT, DAT, DAT, 2'd0, 0, 0, 2'd3, 2'd0, 0, 0, 1));
                end
                3: begin
                    exec_rc = 5'd3; exec_wr = 1'b1; rf_ra = 5'd3; rf_use_ra = 1'b0;
                    push("byp_unused", mk(DAT, DAT, DAT, 2'd0, 0, 0, 2'd0, 2'd0, 0, 0, 1));
                end
                4: begin
                    exec_rc = 5'd7; exec_wr = 1'b1; mem_rc = 5'd3; mem_wr = 1'b1;
                    rf_ra = 5'd3; rf_rb = 5'd7;
                    push("byp_split", mk(DAT, DAT, DAT, 2'd0, 0, 0, 2'd2, 2'd1, 0, 0, 1));
                end
                5: begin
                    exec_rc = 5'd31; exec_wr = 1'b1; mem_rc = 5'd31; mem_wr = 1'b1;
                    wb_rc = 5'd31; wb_wr = 1'b1; rf_ra = 5'd31; rf_rb = 5'd31;
                    push("byp_r31", mk(DAT, DAT, DAT, 2'd0, 0, 0, 2'd0, 2'd0, 0, 0, 1));
                end
                default: begin
                    exec_rc = 5'd1; exec_wr = 1'b1; wb_rc = 5'd0; wb_wr = 1'b1;
                    rf_ra = 5'd0; rf_rb = 5'd31;
                    push("byp_r0", mk(DAT, DAT, DAT, 2'd0, 0, 0, 2'd3, 2'd0, 0, 0, 1));
                end
            endcase
            @(negedge clk);
            n_chk++;
            if (sb_vec.size() == 0) begin
                n_fail++; $display("FAIL bypass: scoreboard empty");
            end else begin
                ev = sb_vec.pop_front(); en = sb_name.pop_front(); ov = obs_vec();
                if (((ov ^ ev[15:0]) & ev[31:16]) !== 16'h0000) begin
                    n_fail++;
                    $display("FAIL %s: observed %b required %b mask %b", en, ov, ev[15:0], ev[31:16]);
                end
            end
        end
    endtask

    task automatic test_load_use();
        logic [31:0] ev; string en; logic [15:0] ov;
        for (int s = 0; s < 7; s++) begin
            @(posedge clk); #1;
            idle();
            case (s)
                0: begin
                    exec_ld = 1'b1; exec_wr = 1'b1; exec_rc = 5'd5; rf_rb = 5'd5; rf_use_rb = 1'b1;
                    push("ld_exec", mk(DAT, NOP, DAT, 2'd0, 1, 0, 2'd0, 2'd0, 0, 0, 0));
                end
                1: begin
                    mem_ld = 1'b1; mem_wr = 1'b1; mem_rc = 5'd5; rf_rb = 5'd5; rf_use_rb = 1'b1;
                    push("ld_mem", mk(DAT, NOP, DAT, 2'd0, 1, 0, 2'd0, 2'd0, 0, 0, 0));
                end
                2: begin
                    wb_wr = 1'b1; wb_rc = 5'd5; rf_rb = 5'd5; rf_use_rb = 1'b1;
                    push("ld_wb", mk(DAT, DAT, DAT, 2'd0, 0, 0, 2'd0, 2'd3, 0, 0, 1));
                end
                3: begin
                    exec_wr = 1'b1; exec_rc = 5'd5; mem_ld = 1'b1; mem_wr = 1'b1; mem_rc = 5'd5;
                    rf_rb = 5'd5; rf_use_rb = 1'b1;
                    push("ld_shadowed", mk(DAT, DAT, DAT, 2'd0, 0, 0, 2'd0, 2'd1, 0, 0, 1));
                end
                4: begin
                    exec_ld = 1'b1; exec_wr = 1'b1; exec_rc = 5'd9; rf_ra = 5'd9; rf_use_ra = 1'b1;
                    rf_branch_taken = 1'b1;
                    push("ld_over_branch", mk(DAT, NOP, DAT, 2'd0, 1, 0, 2'd0, 2'd0, 0, 0, 0));
                end
                5: begin
                    mem_ld = 1'b1; mem_wr = 1'b1; mem_rc = 5'd4; rf_ra = 5'd4;
                    push("ld_unused_src", mk(DAT, DAT, DAT, 2'd0, 0, 0, 2'd0, 2'd0, 0, 0, 1));
                end
                default: begin
                    exec_ld = 1'b1; exec_wr = 1'b1; exec_rc = 5'd31; rf_ra = 5'd31; rf_use_ra = 1'b1;
                    push("ld_r31", mk(DAT, DAT, DAT, 2'd0, 0, 0, 2'd0, 2'd0, 0, 0, 1));
                end
            endcase
            @(negedge clk);
            n_chk++;
            if (sb_vec.size() == 0) begin
                n_fail++; $display("FAIL load_use: scoreboard empty");
            end else begin
                ev = sb_vec.pop_front(); en = sb_name.pop_front(); ov = obs_vec();
                if (((ov ^ ev[15:0]) & ev[31:16]) !== 16'h0000) begin
                    n_fail++;
                    $display("FAIL %s: observed %b required %b mask %b", en, ov, ev[15:0], ev[31:16]);
                end
            end
        end
    endtask

    task automatic test_mem_wait();
        logic [31:0] ev; string en; logic [15:0] ov;
        for (int s = 0; s < 7; s++) begin
            @(posedge clk); #1;
            idle();
            case (s)
                0, 1, 2, 3: begin
                    mem_req = 1'b1; mem_ready = 1'b0; rf_branch_taken = 1'b1;
                    push("memwait_freeze", mk(DAT, DAT, NOP, 2'd0, 0, 1, 2'd0, 2'd0, 0, 0, 1));
                end
                4: begin
                    mem_req = 1'b1; mem_ready = 1'b1; rf_branch_taken = 1'b1;
                    push("memwait_done_branch", mk(NOP, DAT, DAT, 2'd1, 0, 0, 2'd0, 2'd0, 0, 0, 1));
                end
                5: begin
                    mem_req = 1'b1; rf_illegal = 1'b1;
                    exec_ld = 1'b1; exec_wr = 1'b1; exec_rc = 5'd2; rf_ra = 5'd2; rf_use_ra = 1'b1;
                    push("memwait_masks_events", mk(DAT, DAT, NOP, 2'd0, 0, 1, 2'd0, 2'd0, 0, 0, 0));
                end
                default: begin
                    push("memwait_no_exc", mk(DAT, DAT, DAT, 2'd0, 0, 0, 2'd0, 2'd0, 0, 0, 1));
                end
            endcase
            @(negedge clk);
            n_chk++;
            if (sb_vec.size() == 0) begin
                n_fail++; $display("FAIL mem_wait: scoreboard empty");
            end else begin
                ev = sb_vec.pop_front(); en = sb_name.pop_front(); ov = obs_vec();
                if (((ov ^ ev[15:0]) & ev[31:16]) !== 16'h0000) begin
                    n_fail++;
                    $display("FAIL %s step %0d: observed %b required %b mask %b", en, s, ov, ev[15:0], ev[31:16]);
                end
            end
        end
    endtask

    task automatic test_interrupt();
        logic [31:0] ev; string en; logic [15:0] ov;
        for (int s = 0; s < 11; s++) begin
            @(posedge clk); #1;
            idle();
            case (s)
                0: begin irq = 1'b1; push("irq_pulse", mk(DAT, DAT, DAT, 2'd0, 0, 0, 2'd0, 2'd0, 0, 0, 1)); end
                1: push("irq_take", mk(NOP, EXC, DAT, 2'd2, 0, 0, 2'd0, 2'd0, 1, 0, 1));
                2: begin irq = 1'b1; push("irq_exc1", mk(DAT, DAT, DAT, 2'd0, 0, 0, 2'd0, 2'd0, 0, 1, 1)); end
                3: push("irq_masked2", mk(DAT, DAT, DAT, 2'd0, 0, 0, 2'd0, 2'd0, 1, 1, 1));
                4: push("irq_masked3", mk(DAT, DAT, DAT, 2'd0, 0, 0, 2'd0, 2'd0, 1, 1, 1));
                5: push("irq_second_take", mk(NOP, EXC, DAT, 2'd2, 0, 0, 2'd0, 2'd0, 1, 0, 1));
                6: push("irq_drain1", mk(DAT, DAT, DAT, 2'd0, 0, 0, 2'd0, 2'd0, 0, 1, 1));
                7: begin
                    mem_req = 1'b1;
                    push("irq_drain_freeze", mk(DAT, DAT, NOP, 2'd0, 0, 1, 2'd0, 2'd0, 0, 1, 1));
                end
                8: push("irq_drain2", mk(DAT, DAT, DAT, 2'd0, 0, 0, 2'd0, 2'd0, 0, 1, 1));
                9: push("irq_drain3", mk(DAT, DAT, DAT, 2'd0, 0, 0, 2'd0, 2'd0, 0, 1, 1));
                default: push("irq_run", mk(DAT, DAT, DAT, 2'd0, 0, 0, 2'd0, 2'd0, 0, 0, 1));
            endcase
            @(negedge clk);
            n_chk++;
            if (sb_vec.size() == 0) begin
                n_fail++; $display("FAIL interrupt: scoreboard empty");
            end else begin
                ev = sb_vec.pop_front(); en = sb_name.pop_front(); ov = obs_vec();
                if (((ov ^ ev[15:0]) & ev[31:16]) !== 16'h0000) begin
                    n_fail++;
                    $display("FAIL %s: observed %b required %b mask %b", en, ov, ev[15:0], ev[31:16]);
                end
            end
        end
    endtask

    task automatic test_irq_set_wins();
        logic [31:0] ev; string en; logic [15:0] ov;
        for (int s = 0; s < 10; s++) begin
            @(posedge clk); #1;
            idle();
            case (s)
                0: begin irq = 1'b1; push("setwins_req", mk(DAT, DAT, DAT, 2'd0, 0, 0, 2'd0, 2'd0, 0, 0, 1)); end
                1: begin irq = 1'b1; push("setwins_take", mk(NOP, EXC, DAT, 2'd2, 0, 0, 2'd0, 2'd0, 1, 0, 1)); end
                2, 3, 4: push("setwins_kept", mk(DAT, DAT, DAT, 2'd0, 0, 0, 2'd0, 2'd0, 1, 1, 1));
                5: push("setwins_retake", mk(NOP, EXC, DAT, 2'd2, 0, 0, 2'd0, 2'd0, 1, 0, 1));
                6, 7, 8: push("setwins_drain", mk(DAT, DAT, DAT, 2'd0, 0, 0, 2'd0, 2'd0, 0, 1, 1));
                default: push("setwins_run", mk(DAT, DAT, DAT, 2'd0, 0, 0, 2'd0, 2'd0, 0, 0, 1));
            endcase
            @(negedge clk);
            n_chk++;
            if (sb_vec.size() == 0) begin
                n_fail++; $display("FAIL irq_set_wins: scoreboard empty");
            end else begin
                ev = sb_vec.pop_front(); en = sb_name.pop_front(); ov = obs_vec();
                if (((ov ^ ev[15:0]) & ev[31:16]) !== 16'h0000) begin
                    n_fail++;
                    $display("FAIL %s step %0d: observed %b required %b mask %b", en, s, ov, ev[15:0], ev[31:16]);
                end
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [31:0] ev; string en; logic [15:0] ov;
        for (int s = 0; s < 11; s++) begin
            @(posedge clk); #1;
            idle();
            case (s)
                0: begin
                    rf_illegal = 1'b1; rf_branch_taken = 1'b1;
                    exec_ld = 1'b1; exec_wr = 1'b1; exec_rc = 5'd6; rf_ra = 5'd6; rf_use_ra = 1'b1;
                    push("simul_exc_wins", mk(NOP, EXC, DAT, 2'd2, 0, 0, 2'd0, 2'd0, 0, 0, 0));
                end
                1: begin irq = 1'b1; push("simul_busy", mk(DAT, DAT, DAT, 2'd0, 0, 0, 2'd0, 2'd0, 0, 1, 1)); end
                2: begin
                    rf_illegal = 1'b1;
                    push("simul_illegal_in_exc", mk(NOP, EXC, DAT, 2'd2, 0, 0, 2'd0, 2'd0, 1, 1, 1));
                end
                3, 4, 5: push("simul_reloaded", mk(DAT, DAT, DAT, 2'd0, 0, 0, 2'd0, 2'd0, 1, 1, 1));
                6: push("simul_irq_after", mk(NOP, EXC, DAT, 2'd2, 0, 0, 2'd0, 2'd0, 1, 0, 1));
                7, 8, 9: push("simul_drain", mk(DAT, DAT, DAT, 2'd0, 0, 0, 2'd0, 2'd0, 0, 1, 1));
                default: push("simul_run", mk(DAT, DAT, DAT, 2'd0, 0, 0, 2'd0, 2'd0, 0, 0, 1));
            endcase
            @(negedge clk);
            n_chk++;
            if (sb_vec.size() == 0) begin
                n_fail++; $display("FAIL simultaneous: scoreboard empty");
            end else begin
                ev = sb_vec.pop_front(); en = sb_name.pop_front(); ov = obs_vec();
                if (((ov ^ ev[15:0]) & ev[31:16]) !== 16'h0000) begin
                    n_fail++;
                    $display("FAIL %s step %0d: observed %b required %b mask %b", en, s, ov, ev[15:0], ev[31:16]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_drain();
        logic [31:0] ev; string en; logic [15:0] ov;
        for (int s = 0; s < 6; s++) begin
            @(posedge clk); #1;
            idle();
            case (s)
                0: begin
                    rf_illegal = 1'b1; irq = 1'b1;
                    push("rmd_take", mk(NOP, EXC, DAT, 2'd2, 0, 0, 2'd0, 2'd0, 0, 0, 1));
                end
                1: push("rmd_in_exc", mk(DAT, DAT, DAT, 2'd0, 0, 0, 2'd0, 2'd0, 1, 1, 1));
                2: begin
                    rst_n = 1'b0; rf_branch_taken = 1'b1; rf_illegal = 1'b1;
                    rf_ra = 5'd8; rf_use_ra = 1'b1; exec_rc = 5'd8; exec_wr = 1'b1;
                    push("rmd_assert", mk(NOP, NOP, NOP, 2'd0, 0, 0, 2'd0, 2'd0, 1, 1, 1));
                end
                3: begin
                    rst_n = 1'b0; rf_branch_taken = 1'b1;
                    push("rmd_held", mk(NOP, NOP, NOP, 2'd0, 0, 0, 2'd0, 2'd0, 0, 0, 1));
                end
                default: begin
                    rst_n = 1'b1;
                    push("rmd_released", mk(DAT, DAT, DAT, 2'd0, 0, 0, 2'd0, 2'd0, 0, 0, 1));
                end
            endcase
            @(negedge clk);
            n_chk++;
            if (sb_vec.size() == 0) begin
                n_fail++; $display("FAIL reset_mid_drain: scoreboard empty");
            end else begin
                ev = sb_vec.pop_front(); en = sb_name.pop_front(); ov = obs_vec();
                if (((ov ^ ev[15:0]) & ev[31:16]) !== 16'h0000) begin
                    n_fail++;
                    $display("FAIL %s step %0d: observed %b required %b mask %b", en, s, ov, ev[15:0], ev[31:16]);
                end
            end
        end
    endtask

    initial begin
        clk = 1'b0;
        rst_n = 1'b0;
        n_chk = 0;
        n_fail = 0;
        idle();
        test_reset();
        test_bypass();
        test_load_use();
        test_mem_wait();
        test_interrupt();
        test_irq_set_wins();
        test_simultaneous();
        test_reset_mid_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline control unit for the five-stage Beta core (IF, RF, EXEC, MEM, WB). It watches the register fields and op flags of the RF, EXEC, MEM and WB stages. It produces the per-stage `ir_src_*` selects, stall and freeze signals, the PC source select and the operand bypass selects consumed by the RF stage. It also latches interrupt requests and sequences exception entry, masking further interrupts until the injected `BNE_EXCEPT` has drained to WB.

## Interface
- `EXC_DRAIN`, default 3: cycles the IRQ mask stays set after an exception is taken. This is the EXEC→WB distance.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset. One clock; reset is synchronous and active-low.
- `rf_ra`, `rf_rb` in 5: source registers of the instruction in RF.
- `rf_use_ra`, `rf_use_rb` in 1: the RF instruction reads ra / rb.
- `rf_illegal` in 1: the RF instruction has an unimplemented opcode.
- `rf_branch_taken` in 1: the taken BEQ/BNE/JMP is resolved in RF.
- `exec_rc`, `mem_rc`, `wb_rc` in 5: destination registers of EXEC, MEM and WB.
- `exec_wr`, `mem_wr`, `wb_wr` in 1: the stage instruction writes rc.
- `exec_ld`, `mem_ld` in 1: the stage instruction is LD or LDR (`op_ld_or_ldr`).
- `mem_req` in 1: MEM holds an LD, ST or LDR accessing data memory.
- `mem_ready` in 1: data memory completes the access this cycle.
- `irq` in 1: interrupt request, level, synchronous to `clk`.
- `ir_src_rf`, `ir_src_exec`, `ir_src_wb` out 2: IR source for the register entering RF, EXEC and WB. Uses the `IR_SRC_DATA`, `IR_SRC_NOP` and `IR_SRC_EXCEPT` encodings from defines.v.
- `pc_sel` out 2: 0 = PC+4, 1 = branch target, 2 = exception vector, 3 = unused.
- `stall` out 1: hold the PC and the IF/RF pipeline registers.
- `freeze` out 1: hold the PC and the IF, RF, EXEC and MEM pipeline registers.
- `a_byp`, `b_byp` out 2: operand source. 0 = register file, 1 = EXEC y, 2 = MEM y, 3 = WB data.
- `irq_pending` out 1: a latched interrupt is waiting.
- `exc_busy` out 1: the IRQ mask is active (FSM in EXC).

## Operation
- **Matching.** A source matches a stage when `*_wr` is set, rc equals the source, the source is not 31 and the `rf_use_*` bit is set.
- **Bypass.** The nearest matching stage wins, with priority EXEC > MEM > WB. With no match, or when the source is R31, the select is 0.
- **Load-use hazard.** The hazard holds when the nearest match for either used source is a stage with `*_ld` set. In that case:
  - `stall=1`;
  - `ir_src_exec=NOP`;
  - `pc_sel=0`;
  - the bypass selects are don't-care.
- **Memory wait.** When `mem_req & !mem_ready`:
  - `freeze=1`, `ir_src_wb=NOP`;
  - all other selects are `DATA`;
  - `pc_sel=0`;
  - no other event is acted on, and internal counters hold.
- **Exception take condition.** An exception is taken when `!freeze` and either `rf_illegal` is set, or `irq_pending` is set with the FSM in RUN.
- **Exception actions.**
  - `ir_src_exec=EXCEPT` and `ir_src_rf=NOP`;
  - `pc_sel=2`;
  - `stall=0`;
  - the load-use hazard and `rf_branch_taken` are ignored. XP receives the PC of the replaced instruction, which re-executes.
- **Branch.** With `rf_branch_taken` and no higher-priority event: `ir_src_rf=NOP` and `pc_sel=1`.
- **Priority.** freeze > exception > load-use stall > branch > normal. Normal means every `ir_src_*` is `DATA`, `pc_sel=0`, and `stall` and `freeze` are 0.
- **IRQ latch.**
  - `irq_pending` is set on any cycle with `irq=1`.
  - It is cleared on the edge ending a cycle in which an IRQ exception is taken. An illegal-op exception does not clear it.
  - If `irq=1` in the same cycle as the clear, the set wins.
- **FSM, state RUN.** Taking any exception moves to EXC with `cnt=EXC_DRAIN-1`.
- **FSM, state EXC.**
  - Interrupts are masked; `irq_pending` still latches.
  - `rf_illegal` is still taken and reloads `cnt`.
  - Otherwise `cnt` decrements each non-freeze cycle. At `cnt==0` (non-freeze) the FSM returns to RUN.
- **`exc_busy`** is high when the FSM is in EXC.
- **Counter width** is `$clog2(EXC_DRAIN)`, minimum 1. `EXC_DRAIN` must be at least 1.

## Timing
- All outputs except `irq_pending` and `exc_busy` are combinational from the inputs and state, evaluated in the same cycle.
- **While `rst_n=0`:**
  - `ir_src_rf`, `ir_src_exec` and `ir_src_wb` are `NOP`;
  - `stall`, `freeze` and `pc_sel` are 0;
  - both bypass selects are 0.
- **At the reset edge:** state is RUN, `cnt=0` and `irq_pending=0`. Reset asserted mid-exception aborts the drain.
- **IRQ latency.** An `irq` sampled high at edge N sets `irq_pending` after edge N. The earliest take is cycle N+1, provided the FSM is in RUN and there is no freeze.
- **Load-use stalls.**
  - A load in EXEC with a matching RF source gives 2 stall cycles: load in EXEC, then load in MEM.
  - A load in MEM gives 1 stall cycle.
- **Drain window.** After a take in cycle T, `exc_busy` is high in cycles T+1 … T+EXC_DRAIN, excluding freeze cycles, which extend the window.

## Test plan
- **Bypass chain:** `exec_rc=3` (wr), `mem_rc=3` (wr), `wb_rc=3` (wr), `rf_ra=3`, `rf_rb=31` with both used → `a_byp=1`, `b_byp=0`, no stall.
- **Load-use:** `exec_ld=1`, `exec_rc=5`, `rf_rb=5` → `stall=1` and `ir_src_exec=NOP`. Next cycle, with the load now in MEM (`mem_ld=1`, `mem_rc=5`) → stall again. Next cycle, with the load in WB (`wb_rc=5`) → `b_byp=3`, `stall=0`.
- **Memory wait:** `mem_req=1`, `mem_ready=0` for 4 cycles, with `rf_branch_taken=1` held → `freeze=1` and `ir_src_wb=NOP` for exactly 4 cycles, `pc_sel=0`. On the cycle `mem_ready=1` → `pc_sel=1` and `ir_src_rf=NOP`.
- **Interrupt:** pulse `irq` for 1 cycle → `irq_pending` next cycle, then in the take cycle `ir_src_exec=EXCEPT` and `pc_sel=2`. `exc_busy` is high for 3 cycles. A second `irq` during EXC is taken only after `exc_busy` falls.
- **Simultaneous events:** `rf_illegal=1`, `rf_branch_taken=1` and a load-use match in the same cycle → exception wins, with `stall=0` and `pc_sel=2`.
- **Reset mid-drain:** assert `rst_n=0` during EXC with `irq_pending=1` → all outputs at reset values. After release, state is RUN, `exc_busy=0` and `irq_pending=0`.
